pixie_fb_port_arbiter: RTL and testbench

//  Owns frame-buffer write port A (CPU clock domain) and shares it between three requesters:
//  - pixie front-end DMA writes: fixed top priority, never stalled
//  - a frame-buffer clear sequencer
//  - a single-outstanding host (HPS/savestate) read/write port

---
 rtl/pixie_fb_port_arbiter_pkg.sv | 20 ++
 rtl/pixie_fb_clear_seq.sv | 57 +++++
 rtl/pixie_fb_port_arbiter.sv | 131 +++++++++++++
 tb/tb_pixie_fb_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixie_fb_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixie_fb_port_arbiter_pkg: frame geometry and arbiter FSM encodings. r1.0 |
// +--------------------------------------------------------------------------+
package pixie_fb_port_arbiter_pkg;

  localparam int unsigned FB_BYTES_PER_LINE = 8;
  localparam int unsigned FB_LINES          = 128;
  localparam int unsigned FB_DEPTH_DEFAULT  = FB_BYTES_PER_LINE * FB_LINES;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_CLEAR   = 3'd1;
  localparam logic [STATE_W-1:0] S_HOST_WR = 3'd2;
  localparam logic [STATE_W-1:0] S_HOST_RD = 3'd3;
  localparam logic [STATE_W-1:0] S_RD_WAIT = 3'd4;
  localparam logic [STATE_W-1:0] S_ACK     = 3'd5;

endpackage
`default_nettype wire

// File: rtl/pixie_fb_clear_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixie_fb_clear_seq: clear address counter and pending/done tracking. r1.0 |
// +--------------------------------------------------------------------------+
module pixie_fb_clear_seq
  import pixie_fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int FB_DEPTH       = FB_DEPTH_DEFAULT,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              running,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_DEPTH - 1);

  logic              r_pending;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic              w_last;

  assign w_last = (r_addr == c_last_addr);

  // A start while the sweep is running is dropped; pending stays set until the final write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= CLEAR_ON_RESET;
      r_addr    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= step && w_last;
      if (step) begin
        r_addr <= w_last ? '0 : r_addr + 1'b1;
      end
      if (step && w_last) begin
        r_pending <= 1'b0;
      end else if (start && !running) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign addr = r_addr;
  assign busy = r_pending && !reset;
  assign last = w_last;
  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/pixie_fb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixie_fb_port_arbiter: shares FB port A between DMA, clear and host. r1.0 |
// +--------------------------------------------------------------------------+
module pixie_fb_port_arbiter
  import pixie_fb_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W         = 10,
  parameter int                DATA_W         = 8,
  parameter int                FB_DEPTH       = FB_DEPTH_DEFAULT,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              dma_wr_en,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              fb_en,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  input  logic [DATA_W-1:0] fb_rdata
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [DATA_W-1:0]  r_host_rdata;

  logic              w_slot;
  logic              w_dma_go;
  logic              w_free;
  logic              w_clear_go;
  logic              w_host_go;
  logic              w_clear_busy;
  logic              w_clear_last;
  logic [ADDR_W-1:0] w_clear_addr;

  assign w_slot     = clk_enable && !reset;
  assign w_dma_go   = w_slot && dma_wr_en;
  assign w_free     = w_slot && !dma_wr_en;
  // The clear may already write in IDLE so a reset-triggered sweep starts in the first free cycle.
  assign w_clear_go = w_free && w_clear_busy && (r_state == S_IDLE || r_state == S_CLEAR);
  assign w_host_go  = w_free && (r_state == S_HOST_WR || r_state == S_HOST_RD);

  pixie_fb_clear_seq #(
    .ADDR_W         (ADDR_W),
    .FB_DEPTH       (FB_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (clear_start),
    .running (r_state == S_CLEAR),
    .step    (w_clear_go),
    .addr    (w_clear_addr),
    .busy    (w_clear_busy),
    .last    (w_clear_last),
    .done    (clear_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_host_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_RD_WAIT) begin
        r_host_rdata <= fb_rdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_clear_busy) begin
          w_next_state = (w_clear_go && w_clear_last) ? S_IDLE : S_CLEAR;
        end else if (host_req) begin
          w_next_state = host_we ? S_HOST_WR : S_HOST_RD;
        end
      end
      S_CLEAR:   if (w_clear_go && w_clear_last) w_next_state = S_IDLE;
      S_HOST_WR: if (w_host_go) w_next_state = S_ACK;
      S_HOST_RD: if (w_host_go) w_next_state = S_RD_WAIT;
      S_RD_WAIT: w_next_state = S_ACK;
      S_ACK:     w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fb_en    = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    if (w_dma_go) begin
      fb_en    = 1'b1;
      fb_we    = 1'b1;
      fb_addr  = dma_addr;
      fb_wdata = dma_data;
    end else if (w_clear_go) begin
      fb_en    = 1'b1;
      fb_we    = 1'b1;
      fb_addr  = w_clear_addr;
      fb_wdata = CLEAR_VALUE;
    end else if (w_host_go) begin
      fb_en    = 1'b1;
      fb_we    = (r_state == S_HOST_WR);
      fb_addr  = host_addr;
      fb_wdata = host_wdata;
    end
  end

  assign host_ack   = (r_state == S_ACK) && !reset;
  assign host_rdata = r_host_rdata;
  assign clear_busy = w_clear_busy;

endmodule
`default_nettype wire

// File: tb/tb_pixie_fb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixie_fb_port_arbiter: directed scoreboard bench for the arbiter. r1.0 |
// +--------------------------------------------------------------------------+
module tb_pixie_fb_port_arbiter;

  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_enable = 1'b0;
  logic       dma_wr_en = 1'b0;
  logic [9:0] dma_addr = '0;
  logic [7:0] dma_data = '0;
  logic       clear_start = 1'b0;
  logic       clear_busy;
  logic       clear_done;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [9:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       fb_en;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic [7:0] fb_rdata = '0;

  typedef struct { int cyc; logic we; logic [9:0] addr; logic [7:0] data; } fb_exp_t;
  typedef struct { int cyc; logic rd; logic [7:0] data; } ack_exp_t;

  fb_exp_t  fb_q[$];
  ack_exp_t ack_q[$];
  int       done_q[$];
  fb_exp_t  m_fb;
  ack_exp_t m_ack;
  int       m_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] mem [0:DEPTH-1];

  pixie_fb_port_arbiter #(
    .ADDR_W         (10),
    .DATA_W         (8),
    .FB_DEPTH       (DEPTH),
    .CLEAR_VALUE    (8'h00),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .dma_wr_en   (dma_wr_en),
    .dma_addr    (dma_addr),
    .dma_data    (dma_data),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .fb_en       (fb_en),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .fb_rdata    (fb_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer port A model: synchronous read with one clock of latency.
  always @(posedge clk) begin
    if (fb_en) begin
      if (fb_we) mem[fb_addr] <= fb_wdata;
      fb_rdata <= mem[fb_addr];
    end
  end

  // Monitor: every DUT output event is matched against the head of its queue.
  always @(negedge clk) begin
    while (fb_q.size() > 0 && fb_q[0].cyc < cyc) begin
      m_fb = fb_q.pop_front();
      checks++; failures++;
      $display("FAIL fb_missing: cycle=%0d got no access, required we=%b addr=%h", m_fb.cyc, m_fb.we, m_fb.addr);
    end
    while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
      m_ack = ack_q.pop_front();
      checks++; failures++;
      $display("FAIL ack_missing: cycle=%0d got no host_ack, required one", m_ack.cyc);
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      m_done = done_q.pop_front();
      checks++; failures++;
      $display("FAIL done_missing: cycle=%0d got no clear_done, required one", m_done);
    end
    if (fb_en) begin
      checks++;
      if (fb_q.size() == 0) begin
        failures++;
        $display("FAIL fb_unexpected: cycle=%0d got we=%b addr=%h data=%h, required no access", cyc, fb_we, fb_addr, fb_wdata);
      end else begin
        m_fb = fb_q.pop_front();
        if (m_fb.cyc != cyc || fb_we !== m_fb.we || fb_addr !== m_fb.addr ||
            (m_fb.we && fb_wdata !== m_fb.data) || clk_enable !== 1'b1) begin
          failures++;
          $display("FAIL fb_access: got cyc=%0d we=%b addr=%h data=%h en=%b, required cyc=%0d we=%b addr=%h data=%h en=1",
                   cyc, fb_we, fb_addr, fb_wdata, clk_enable, m_fb.cyc, m_fb.we, m_fb.addr, m_fb.data);
        end
      end
    end
    if (host_ack) begin
      checks++;
      if (ack_q.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected: cycle=%0d got host_ack, required none", cyc);
      end else begin
        m_ack = ack_q.pop_front();
        if (m_ack.cyc != cyc || (m_ack.rd && host_rdata !== m_ack.data)) begin
          failures++;
          $display("FAIL host_ack: got cyc=%0d rdata=%h, required cyc=%0d rdata=%h", cyc, host_rdata, m_ack.cyc, m_ack.data);
        end
      end
    end
    if (clear_done) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: cycle=%0d got clear_done, required none", cyc);
      end else begin
        m_done = done_q.pop_front();
        if (m_done != cyc) begin
          failures++;
          $display("FAIL clear_done: got cyc=%0d, required cyc=%0d", cyc, m_done);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clk_enable = 1'b1; dma_wr_en = 1'b0; clear_start = 1'b0; host_req = 1'b0;
    tick(); tick();
    check("rst_fb_en", 32'(fb_en), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_host_ack", 32'(host_ack), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_clear_busy", 32'(clear_busy), 32'd1);
  endtask

  // Runs a clear that begins in the current cycle; stops after 'stop_after' clear writes.
  task automatic run_clear(input int en_period, input int dma_period, input int stop_after, input int pulse_at);
    int n = 0;
    int k = 0;
    int d = 0;
    int en_cnt = 0;
    while (n < stop_after && k < 20000) begin
      clk_enable  = (k % en_period == 0);
      dma_wr_en   = 1'b0;
      clear_start = (n == pulse_at);
      if (clk_enable) begin
        if (dma_period > 0 && en_cnt % dma_period == dma_period - 1) begin
          dma_wr_en = 1'b1;
          dma_addr  = 10'(n + 512);
          dma_data  = 8'(d + 1);
          fb_q.push_back('{cyc, 1'b1, dma_addr, dma_data});
          d++;
        end else begin
          fb_q.push_back('{cyc, 1'b1, 10'(n), 8'h00});
          n++;
          if (n == DEPTH) done_q.push_back(cyc + 1);
        end
        en_cnt++;
      end
      tick();
      k++;
    end
    dma_wr_en = 1'b0; clear_start = 1'b0; clk_enable = 1'b1;
    if (stop_after == DEPTH) check("busy_after_clear", 32'(clear_busy), 32'd0);
  endtask

  task automatic host_op(input logic we, input logic [9:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata, input bit dma_first);
    int g;
    int a;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    g = cyc + 1 + (dma_first ? 1 : 0);
    a = g + (we ? 1 : 2);
    ack_q.push_back('{a, !we, exp_rdata});
    tick();
    if (dma_first) begin
      dma_wr_en = 1'b1; dma_addr = 10'h2AA; dma_data = 8'h3C;
      fb_q.push_back('{cyc, 1'b1, dma_addr, dma_data});
      tick();
      dma_wr_en = 1'b0;
    end
    fb_q.push_back('{cyc, we, addr, wdata});
    while (cyc <= a) tick();
    host_req = 1'b0;
  endtask

  initial begin
    int s;
    // Power-on clear with every cycle enabled.
    do_reset();
    run_clear(1, 0, DEPTH, -1);
    tick();
    // Clear requested by pulse, DMA on every 4th slot, ignored restart request mid-sweep.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    #1 check("start_clear_busy", 32'(clear_busy), 32'd1);
    run_clear(1, 4, DEPTH, 500);
    tick(); tick();
    // Host write, readback, and readback preempted by DMA.
    host_op(1'b1, 10'h155, 8'hA5, 8'h00, 1'b0);
    tick();
    host_op(1'b0, 10'h155, 8'h00, 8'hA5, 1'b0);
    tick();
    host_op(1'b0, 10'h155, 8'h00, 8'hA5, 1'b1);
    tick();
    // Host request waiting for a whole clear.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    s = cyc;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 8'h5A;
    ack_q.push_back('{s + 1026, 1'b0, 8'h00});
    run_clear(1, 0, DEPTH, -1);
    fb_q.push_back('{s + 1025, 1'b1, 10'h3FF, 8'h5A});
    while (cyc <= s + 1026) tick();
    host_req = 1'b0;
    tick();
    host_op(1'b0, 10'h3FF, 8'h00, 8'h5A, 1'b0);
    tick();
    host_op(1'b0, 10'h155, 8'h00, 8'h00, 1'b0);
    tick();
    // Clear with one enabled cycle in eight.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    run_clear(8, 0, DEPTH, -1);
    tick();
    // Reset in the middle of a clear, then a full restart from address 0.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    run_clear(1, 0, 300, -1);
    do_reset();
    run_clear(1, 0, DEPTH, -1);
    tick(); tick(); tick();
    while (fb_q.size() > 0) begin
      m_fb = fb_q.pop_front();
      checks++; failures++;
      $display("FAIL fb_leftover: got nothing, required cyc=%0d addr=%h", m_fb.cyc, m_fb.addr);
    end
    while (ack_q.size() > 0) begin
      m_ack = ack_q.pop_front();
      checks++; failures++;
      $display("FAIL ack_leftover: got nothing, required cyc=%0d", m_ack.cyc);
    end
    while (done_q.size() > 0) begin
      m_done = done_q.pop_front();
      checks++; failures++;
      $display("FAIL done_leftover: got nothing, required cyc=%0d", m_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
